// File: rtl/dense_dot25_calc.sv
// dense_dot25_calc: 25-element fixed-point dot product plus bias, with
// multi-chunk accumulation for neurons whose fan-in exceeds N.
// Four register stages: products, partial sums, chunk accumulate,
// round/saturate. One chunk per cycle, no backpressure.
// Optional build macro DOT25_RELU_EN: apply ReLU to the saturated result.
module dense_dot25_calc #(
   parameter int WIDTH = 16,
   parameter int N     = 25,
   parameter int FRAC  = 8,
   parameter int ACC_W = 40
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid_i,
   input  logic                       in_first_i,
   input  logic                       in_last_i,
   input  logic [WIDTH*(2*N+1)-1:0]   data_in_i,
   output logic                       out_valid_o,
   output logic [WIDTH-1:0]           data_out_o,
   output logic                       ovf_o,
   output logic                       seq_err_o,
   output logic                       busy_o
);

   localparam int PROD_W = 2 * WIDTH;
   localparam int GROUPS = 5;
   localparam int GRP_SZ = (N + GROUPS - 1) / GROUPS;
   localparam logic signed [ACC_W-1:0] SAT_MAX  = (ACC_W'(1) <<< (WIDTH - 1)) - ACC_W'(1);
   localparam logic signed [ACC_W-1:0] SAT_MIN  = -(ACC_W'(1) <<< (WIDTH - 1));
   localparam logic signed [ACC_W-1:0] ROUND_K  = ACC_W'(1) <<< (FRAC - 1);

   // Unpacked views of the two operand vectors
   logic signed [WIDTH-1:0] vec_a [N];
   logic signed [WIDTH-1:0] vec_b [N];

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_unpack
         assign vec_b[gi] = data_in_i[WIDTH*(1+gi)   +: WIDTH];
         assign vec_a[gi] = data_in_i[WIDTH*(N+1+gi) +: WIDTH];
      end
   endgenerate

   // ---------------- S1: products ----------------
   logic signed [PROD_W-1:0] s1_prod_reg [N];
   logic signed [WIDTH-1:0]  s1_bias_reg;
   logic                     s1_valid_reg, s1_first_reg, s1_last_reg;

   // Register element-wise products; flags are qualified by in_valid_i
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_reg <= 1'b0;
         s1_first_reg <= 1'b0;
         s1_last_reg  <= 1'b0;
         s1_bias_reg  <= '0;
         for (int k = 0; k < N; k++) s1_prod_reg[k] <= '0;
      end else begin
         s1_valid_reg <= in_valid_i;
         s1_first_reg <= in_valid_i & in_first_i;
         s1_last_reg  <= in_valid_i & in_last_i;
         if (in_valid_i) begin
            s1_bias_reg <= data_in_i[WIDTH-1:0];
            for (int k = 0; k < N; k++)
               s1_prod_reg[k] <= PROD_W'(vec_a[k]) * PROD_W'(vec_b[k]);
         end
      end
   end

   // ---------------- S2: partial sums ----------------
   logic signed [ACC_W-1:0] s2_part_next [GROUPS];
   logic signed [ACC_W-1:0] s2_part_reg  [GROUPS];
   logic signed [WIDTH-1:0] s2_bias_reg;
   logic                    s2_valid_reg, s2_first_reg, s2_last_reg;

   // Sum products in groups of GRP_SZ, sign-extended to accumulator width
   always_comb begin
      for (int g = 0; g < GROUPS; g++) begin
         s2_part_next[g] = '0;
         for (int j = 0; j < GRP_SZ; j++) begin
            if (g * GRP_SZ + j < N)
               s2_part_next[g] = s2_part_next[g] + ACC_W'(s1_prod_reg[g*GRP_SZ+j]);
         end
      end
   end

   // Register partial sums and carry the chunk flags forward
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid_reg <= 1'b0;
         s2_first_reg <= 1'b0;
         s2_last_reg  <= 1'b0;
         s2_bias_reg  <= '0;
         for (int g = 0; g < GROUPS; g++) s2_part_reg[g] <= '0;
      end else begin
         s2_valid_reg <= s1_valid_reg;
         s2_first_reg <= s1_first_reg;
         s2_last_reg  <= s1_last_reg;
         s2_bias_reg  <= s1_bias_reg;
         for (int g = 0; g < GROUPS; g++) s2_part_reg[g] <= s2_part_next[g];
      end
   end

   // ---------------- S3: chunk accumulate ----------------
   logic signed [ACC_W-1:0] acc_reg, s3_total_reg;
   logic signed [ACC_W-1:0] bias_ext, seed, total;
   logic                    open_reg, seq_err_reg, s3_valid_reg, s3_last_reg;
   logic                    seq_bad;

   // Seed from bias on a first chunk, otherwise from the running accumulator
   always_comb begin
      bias_ext = ACC_W'(s2_bias_reg) <<< FRAC;
      seed     = s2_first_reg ? bias_ext : acc_reg;
      total    = seed;
      for (int g = 0; g < GROUPS; g++) total = total + s2_part_reg[g];
      // A first chunk into an open neuron, or a continuation with none open
      seq_bad  = s2_valid_reg & (s2_first_reg == open_reg);
   end

   // Update accumulator/open flag; a last chunk hands its total to S4
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_reg      <= '0;
         open_reg     <= 1'b0;
         seq_err_reg  <= 1'b0;
         s3_total_reg <= '0;
         s3_valid_reg <= 1'b0;
         s3_last_reg  <= 1'b0;
      end else begin
         s3_valid_reg <= s2_valid_reg;
         s3_last_reg  <= s2_valid_reg & s2_last_reg;
         if (seq_bad) seq_err_reg <= 1'b1;
         if (s2_valid_reg) begin
            s3_total_reg <= total;
            acc_reg      <= s2_last_reg ? '0 : total;
            open_reg     <= ~s2_last_reg;
         end
      end
   end

   // ---------------- S4: round, saturate, output ----------------
   logic signed [ACC_W-1:0] rounded, shifted;
   logic [WIDTH-1:0]        res_next;
   logic                    ovf_next;

   // Round half-up, drop the fraction, clamp to the output range
   always_comb begin
      rounded  = s3_total_reg + ROUND_K;
      shifted  = rounded >>> FRAC;
      res_next = shifted[WIDTH-1:0];
      ovf_next = 1'b0;
      if (shifted > SAT_MAX) begin
         res_next = SAT_MAX[WIDTH-1:0];
         ovf_next = 1'b1;
      end else if (shifted < SAT_MIN) begin
         res_next = SAT_MIN[WIDTH-1:0];
         ovf_next = 1'b1;
      end
`ifdef DOT25_RELU_EN
      if (shifted < 0) begin
         res_next = '0;
         ovf_next = 1'b0;
      end
`endif
   end

   // Register the result only for neuron-closing chunks; data holds otherwise
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_o <= 1'b0;
         data_out_o  <= '0;
         ovf_o       <= 1'b0;
      end else begin
         out_valid_o <= s3_valid_reg & s3_last_reg;
         ovf_o       <= s3_valid_reg & s3_last_reg & ovf_next;
         if (s3_valid_reg & s3_last_reg) data_out_o <= res_next;
      end
   end

   assign seq_err_o = seq_err_reg;
   assign busy_o    = s1_valid_reg | s2_valid_reg | s3_valid_reg | out_valid_o;

endmodule

// File: tb/tb_dense_dot25_calc.sv
// Directed bench for dense_dot25_calc: vector table of single-chunk
// neurons plus hand-written multi-cycle sequences.
module tb_dense_dot25_calc;

   localparam int W  = 16;
   localparam int N  = 25;
   localparam int DW = W * (2 * N + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid_i = 1'b0;
   logic          in_first_i = 1'b0;
   logic          in_last_i = 1'b0;
   logic [DW-1:0] data_in_i = '0;
   logic          out_valid_o;
   logic [W-1:0]  data_out_o;
   logic          ovf_o;
   logic          seq_err_o;
   logic          busy_o;

   dense_dot25_calc dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (in_valid_i),
      .in_first_i  (in_first_i),
      .in_last_i   (in_last_i),
      .data_in_i   (data_in_i),
      .out_valid_o (out_valid_o),
      .data_out_o  (data_out_o),
      .ovf_o       (ovf_o),
      .seq_err_o   (seq_err_o),
      .busy_o      (busy_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] bias;
      logic        all_el;
      logic [15:0] exp_d;
      logic        exp_ovf;
   } vec_t;

   typedef struct {
      int          cyc;
      logic [15:0] d;
      logic        o;
   } res_t;

   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   res_t resq[$];
   vec_t vecs[7];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst && out_valid_o) resq.push_back('{cyc, data_out_o, ovf_o});
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] pack(input logic [15:0] a, input logic [15:0] b,
                                          input logic [15:0] bias, input logic all_el);
      logic [DW-1:0] w;
      w = '0;
      w[15:0] = bias;
      for (int k = 0; k < N; k++) begin
         if (all_el || k == 0) begin
            w[16 + 16*k +: 16]  = b;
            w[416 + 16*k +: 16] = a;
         end
      end
      return w;
   endfunction

   // Drive one chunk for one cycle; t returns the cycle it is presented in
   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [15:0] bias,
                       input logic all_el, input logic first, input logic last, output int t);
      @(negedge clk);
      in_valid_i = 1'b1;
      in_first_i = first;
      in_last_i  = last;
      data_in_i  = pack(a, b, bias, all_el);
      t = cyc;
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      in_valid_i = 1'b0;
      in_first_i = 1'b1;   // must be ignored while in_valid_i is low
      in_last_i  = 1'b1;
      data_in_i  = '0;
      repeat (n - 1) @(negedge clk);
   endtask

   initial begin
      int   t, t0;
      res_t r;

      vecs[0] = '{16'h0100, 16'h0100, 16'h0000, 1'b1, 16'h1900, 1'b0};
      vecs[1] = '{16'h7FFF, 16'h7FFF, 16'h0000, 1'b1, 16'h7FFF, 1'b1};
      vecs[2] = '{16'h8000, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b1};
      vecs[3] = '{16'h0001, 16'h0080, 16'h0000, 1'b0, 16'h0001, 1'b0};
      vecs[4] = '{16'hFFFF, 16'h0080, 16'h0000, 1'b0, 16'h0000, 1'b0};
`ifdef DOT25_RELU_EN
      vecs[5] = '{16'hFF00, 16'h0100, 16'h0000, 1'b1, 16'h0000, 1'b0};
`else
      vecs[5] = '{16'hFF00, 16'h0100, 16'h0000, 1'b1, 16'hE700, 1'b0};
`endif
      vecs[6] = '{16'h0000, 16'h0000, 16'h0123, 1'b1, 16'h0123, 1'b0};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
      check("rst_data", {16'd0, data_out_o}, 32'd0);
      check("rst_ovf", {31'd0, ovf_o}, 32'd0);
      check("rst_seq_err", {31'd0, seq_err_o}, 32'd0);
      check("rst_busy", {31'd0, busy_o}, 32'd0);
      rst = 1'b0;
      idle(2);

      // Single-chunk neurons from the table
      for (int i = 0; i < 7; i++) begin
         resq.delete();
         send(vecs[i].a, vecs[i].b, vecs[i].bias, vecs[i].all_el, 1'b1, 1'b1, t);
         idle(8);
         check($sformatf("vec%0d_count", i), resq.size(), 32'd1);
         if (resq.size() > 0) begin
            r = resq.pop_front();
            $display("vec%0d: data=%h ovf=%b cyc=%0d", i, r.d, r.o, r.cyc);
            check($sformatf("vec%0d_data", i), {16'd0, r.d}, {16'd0, vecs[i].exp_d});
            check($sformatf("vec%0d_ovf", i), {31'd0, r.o}, {31'd0, vecs[i].exp_ovf});
            check($sformatf("vec%0d_latency", i), r.cyc, t + 4);
         end
      end

      // Two-chunk neuron; second chunk's bias must be ignored
      resq.delete();
      send(16'h0100, 16'h0080, 16'h0200, 1'b1, 1'b1, 1'b0, t0);
      send(16'h0100, 16'h0080, 16'h7FFF, 1'b1, 1'b0, 1'b1, t);
      idle(8);
      check("two_chunk_count", resq.size(), 32'd1);
      if (resq.size() > 0) begin
         r = resq.pop_front();
         $display("two_chunk: data=%h ovf=%b cyc=%0d", r.d, r.o, r.cyc);
         check("two_chunk_data", {16'd0, r.d}, 32'h1B00);
         check("two_chunk_ovf", {31'd0, r.o}, 32'd0);
         check("two_chunk_latency", r.cyc, t + 4);
      end
      check("hold_data", {16'd0, data_out_o}, 32'h1B00);
      check("hold_valid", {31'd0, out_valid_o}, 32'd0);
      check("no_seq_err_yet", {31'd0, seq_err_o}, 32'd0);
      check("idle_busy", {31'd0, busy_o}, 32'd0);

      // Throughput: four back-to-back neurons of 1.0 .. 4.0
      resq.delete();
      send(16'h0100, 16'h0100, 16'h0000, 1'b0, 1'b1, 1'b1, t0);
      send(16'h0100, 16'h0200, 16'h0000, 1'b0, 1'b1, 1'b1, t);
      send(16'h0100, 16'h0300, 16'h0000, 1'b0, 1'b1, 1'b1, t);
      send(16'h0100, 16'h0400, 16'h0000, 1'b0, 1'b1, 1'b1, t);
      idle(8);
      check("tput_count", resq.size(), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (resq.size() > 0) begin
            r = resq.pop_front();
            $display("tput%0d: data=%h cyc=%0d", i, r.d, r.cyc);
            check($sformatf("tput%0d_data", i), {16'd0, r.d}, (i + 1) * 256);
            check($sformatf("tput%0d_cyc", i), r.cyc, t0 + 4 + i);
         end
      end

      // Protocol error: a new first chunk while a neuron is still open
      resq.delete();
      send(16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b1, 1'b0, t0);
      send(16'h0100, 16'h0300, 16'h0000, 1'b0, 1'b1, 1'b1, t);
      idle(8);
      check("proto_count", resq.size(), 32'd1);
      if (resq.size() > 0) begin
         r = resq.pop_front();
         $display("proto: data=%h cyc=%0d seq_err=%b", r.d, r.cyc, seq_err_o);
         check("proto_data", {16'd0, r.d}, 32'h0300);
      end
      check("seq_err_set", {31'd0, seq_err_o}, 32'd1);
      idle(5);
      check("seq_err_sticky", {31'd0, seq_err_o}, 32'd1);

      // Reset while two last chunks are in flight
      resq.delete();
      send(16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b1, 1'b1, t0);
      send(16'h0100, 16'h0200, 16'h0000, 1'b1, 1'b1, 1'b1, t);
      @(negedge clk);
      in_valid_i = 1'b0;
      check("inflight_busy", {31'd0, busy_o}, 32'd1);
      rst = 1'b1;
      #1;
      check("mid_rst_busy", {31'd0, busy_o}, 32'd0);
      repeat (2) @(negedge clk);
      check("mid_rst_seq_err", {31'd0, seq_err_o}, 32'd0);
      check("mid_rst_valid", {31'd0, out_valid_o}, 32'd0);
      rst = 1'b0;
      idle(8);
      check("flushed_count", resq.size(), 32'd0);
      check("post_rst_busy", {31'd0, busy_o}, 32'd0);
      resq.delete();
      send(16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b1, 1'b1, t);
      idle(8);
      check("post_rst_count", resq.size(), 32'd1);
      if (resq.size() > 0) begin
         r = resq.pop_front();
         $display("post_rst: data=%h cyc=%0d", r.d, r.cyc);
         check("post_rst_data", {16'd0, r.d}, 32'h1900);
         check("post_rst_latency", r.cyc, t + 4);
      end
      check("post_rst_seq_err", {31'd0, seq_err_o}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/dense_dot25_calc.md
Name: dense_dot25_calc

Overview:
- Fixed-point compute engine sitting directly downstream of the dense-layer controller. It consumes the packed {VecA, VecB, Bias} word the controller drives and returns one 16-bit result to the controller's result input.
- Computes a 25-element dot product plus bias in Q(WIDTH-FRAC).FRAC format.
- Supports accumulating several 25-element chunks into one output, so the controller can evaluate dense neurons with fan-in larger than 25.
- Fully pipelined: accepts one chunk per cycle, no backpressure.

Parameters:
- WIDTH, 16: word width, signed two's complement.
- N, 25: elements per vector chunk.
- FRAC, 8: fractional bits of every operand and of the result.
- ACC_W, 40: internal accumulator width, signed.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high.
- in_valid_i  input  1  chunk present on data_in_i this cycle.
- in_first_i  input  1  chunk opens a new neuron; bias is added. Qualified by in_valid_i.
- in_last_i  input  1  chunk closes the neuron; result is emitted. Qualified by in_valid_i.
- data_in_i  input  WIDTH*(2N+1)  packed {VecA, VecB, Bias}.
  - Bias at [15:0].
  - VecB element k at [16+16k +: 16].
  - VecA element k at [416+16k +: 16].
- out_valid_o  output  1  one-cycle pulse; data_out_o valid.
- data_out_o  output  WIDTH  rounded, saturated result.
- ovf_o  output  1  pulses with out_valid_o when the result saturated.
- seq_err_o  output  1  sticky protocol-error flag; cleared only by rst.
- busy_o  output  1  high while any pipeline stage holds a valid chunk.

Behaviour:
- Reset (async, rst=1):
  - All stage valids cleared; accumulator cleared to 0; "neuron open" flag cleared.
  - out_valid_o=0, data_out_o=0, ovf_o=0, seq_err_o=0, busy_o=0.
  - Reset asserted mid-operation discards every in-flight chunk; no output is ever produced for it.
- Pipeline, with first/last flags carried alongside each stage:
  - S1: register the N signed products A[k]*B[k], each 2*WIDTH bits.
  - S2: register 5 partial sums, each summing 5 products, sign-extended to ACC_W.
  - S3: chunk sum = sum of the 5 partials, plus a seed:
    - first=1: seed = sign-extended Bias << FRAC.
    - first=0: seed = accumulator.
    - If last=0, the accumulator takes the new total.
    - If last=1, the total passes to S4 and the accumulator clears to 0.
  - S4: round-half-up by adding 1<<(FRAC-1), arithmetic shift right by FRAC, then saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. Register data_out_o, out_valid_o and ovf_o.
- Latency: a last chunk accepted at cycle T produces out_valid_o at T+4.
- Back-to-back chunks: accepted every cycle.
  - S3 uses the accumulator value written in the previous cycle (natural forwarding); no bubbles.
- Non-last chunks never raise out_valid_o. data_out_o holds its last value when out_valid_o=0.
- Sequence rules, evaluated at S3:
  - first=1 while a neuron is open: previous partial discarded, new neuron starts, seq_err_o set.
  - first=0 while no neuron is open: seed = accumulator (0), no bias added, seq_err_o set.
  - first=1 and last=1 together: a single-chunk neuron; legal.
- in_first_i and in_last_i are ignored when in_valid_i=0.
- Arithmetic:
  - 2^5 * 2^(2*WIDTH-1) fits in ACC_W=40 for up to 8 chunks.
  - Overflow beyond ACC_W wraps silently; the bench must not exceed 8 chunks per neuron.
- busy_o = OR of S1..S4 valids, registered with the stages.

Optional Feature:
- Macro DOT25_RELU_EN.
- Defined: S4 output stage applies ReLU after saturation; negative results become 0x0000 and ovf_o reflects only positive saturation.
- Undefined: signed result is passed through unchanged.
- Latency is 4 cycles in both cases.

Test Plan:
- Single chunk: A[k]=B[k]=0x0100, Bias=0x0000, first=last=1 at T -> out_valid_o at T+4, data_out_o=0x1900, ovf_o=0.
- Two-chunk neuron:
  - Chunk1: first=1, A=0x0100, B=0x0080, Bias=0x0200.
  - Chunk2: last=1, same A/B, Bias=0x7FFF (must be ignored).
  - Response: exactly one out_valid_o, data_out_o=0x1B00.
- Saturation and rounding:
  - A[k]=B[k]=0x7FFF -> data_out_o=0x7FFF, ovf_o=1.
  - A[k]=0x8000, B[k]=0x7FFF -> 0x8000, ovf_o=1.
  - Only A[0]=0x0001, B[0]=0x0080 nonzero -> 0x0001.
  - Only A[0]=0xFFFF, B[0]=0x0080 nonzero -> 0x0000.
- Throughput: 4 consecutive single-chunk neurons with results 1.0, 2.0, 3.0, 4.0 -> out_valid_o high 4 consecutive cycles with 0x0100, 0x0200, 0x0300, 0x0400 in order.
- Protocol errors: second first=1 chunk while a neuron is open -> seq_err_o=1 and stays high; result equals the second neuron only.
- Reset mid-flight: assert rst 2 cycles after accepting 2 last chunks -> no out_valid_o; busy_o=0 and seq_err_o=0 after reset; the next neuron computes correctly.
- With DOT25_RELU_EN defined: A[k]=0xFF00, B[k]=0x0100 -> 0x0000. Without it -> 0xE700.
